// File: rtl/prefetch_unit_pkg.sv
// prefetch_unit_pkg: shared core constants and helpers for the prefetch unit
package prefetch_unit_pkg;
  localparam int XLEN_DEF = 32;
  localparam int DEPTH_DEF = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0004;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic logic misaligned(input logic [1:0] lo);
    return |lo;
  endfunction
endpackage

// File: rtl/prefetch_unit_if.sv
// prefetch_unit_if: instruction memory and decode-side handshake bundle
interface prefetch_unit_if
  import prefetch_unit_pkg::*;
#(parameter int XLEN = XLEN_DEF);
  logic im_req;
  logic [XLEN-1:0] im_addr;
  logic im_ack;
  logic [31:0] im_do;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic out_misaligned;
  modport master(
    output im_req, im_addr, out_valid, out_inst, out_pc, out_misaligned,
    input im_ack, im_do, out_ready
  );
  modport slave(
    input im_req, im_addr, out_valid, out_inst, out_pc, out_misaligned,
    output im_ack, im_do, out_ready
  );
endinterface

// File: rtl/prefetch_unit_sync_fifo.sv
// sync_fifo: power-of-two circular queue with registered pointers and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic resetb,
  input logic clr,
  input logic push,
  input logic pop,
  input logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign rdata = mem[rd];
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (clr) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= push ? wr + AW'(1) : wr;
      rd <= pop ? rd + AW'(1) : rd;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push && !clr) mem[wr] <= wdata;
endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: single-outstanding instruction fetcher with reserved-slot queue, flush and misaligned marker
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input logic clk,
  input logic resetb,
  input logic redirect_valid,
  input logic [XLEN-1:0] redirect_pc,
  input logic exception_take,
  prefetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = 32 + XLEN + 1;
  logic req, discard, halted, flush, accept, mark, push, pop, go, pend_n;
  logic [XLEN-1:0] addr, pc, pc_n, tgt;
  logic [AW:0] cnt, cnt_n;
  logic [W-1:0] wdata, rdata;
  assign flush = exception_take | redirect_valid;
  assign tgt = exception_take ? EXC_VECTOR : redirect_pc;
  assign accept = req & bus.im_ack & ~discard;
  assign mark = ~flush & ~halted & ~req & misaligned(pc[1:0]) & (cnt < (AW+1)'(DEPTH));
  assign push = (accept & ~flush) | mark;
  assign pop = bus.out_valid & bus.out_ready & ~flush;
  assign pend_n = req & ~bus.im_ack;
  assign pc_n = flush ? tgt : accept ? addr + XLEN'(4) : pc;
  assign cnt_n = flush ? '0 : cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign go = ~pend_n & (flush | ~halted) & (cnt_n < (AW+1)'(DEPTH)) & ~misaligned(pc_n[1:0]);
  assign wdata = mark ? {NOP, pc, 1'b1} : {bus.im_do, addr, 1'b0};
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      req <= 1'b0;
      discard <= 1'b0;
      halted <= 1'b0;
      addr <= RESET_VECTOR;
      pc <= RESET_VECTOR;
    end else begin
      req <= pend_n | go;
      discard <= pend_n & (discard | flush);
      halted <= ~flush & (halted | mark);
      addr <= go ? pc_n : addr;
      pc <= pc_n;
    end
  sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk,
    .resetb,
    .clr(flush),
    .push,
    .pop,
    .wdata,
    .rdata,
    .count(cnt)
  );
  assign bus.im_req = req;
  assign bus.im_addr = addr;
  assign bus.out_valid = |cnt;
  assign {bus.out_inst, bus.out_pc, bus.out_misaligned} = rdata;
endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit: scoreboard bench comparing the decode-side stream against an ideal fetch-stream model
module tb_prefetch_unit;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0004;
  localparam logic [31:0] NOP_I = 32'h0000_0013;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic mis;
  } exp_t;
  logic clk = 1'b0;
  logic resetb, redirect_valid, exception_take;
  logic [31:0] redirect_pc;
  int tests = 0, fails = 0, acks = 0;
  int unsigned ack_pct = 100;
  exp_t sb[$];
  logic pend_q = 1'b0;
  logic [31:0] addr_q = '0;
  prefetch_unit_if #(.XLEN(32)) bus();
  prefetch_unit dut (
    .clk(clk),
    .resetb(resetb),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .exception_take(exception_take),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_1234;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic restart(input logic [31:0] t);
    logic [31:0] p;
    sb.delete();
    p = t;
    if (t[1:0] != 2'b00) sb.push_back('{NOP_I, t, 1'b1});
    else for (int i = 0; i < 256; i++) begin
      sb.push_back('{mem_f(p), p, 1'b0});
      p = p + 32'd4;
    end
  endtask
  task automatic flush(input logic exc, input logic rv, input logic [31:0] t);
    exception_take = exc;
    redirect_valid = rv;
    redirect_pc = t;
    restart(exc ? EV : t);
    step(1);
    exception_take = 1'b0;
    redirect_valid = 1'b0;
  endtask
  always @(posedge clk) begin
    #2;
    bus.im_ack = bus.im_req && ($urandom_range(99) < ack_pct);
    bus.im_do = mem_f(bus.im_addr);
  end
  always @(negedge clk) begin
    exp_t e;
    logic fl;
    if (!resetb) pend_q <= 1'b0;
    else begin
      fl = redirect_valid | exception_take;
      if (pend_q) begin
        check("req_hold", 32'(bus.im_req), 1);
        check("addr_hold", bus.im_addr, addr_q);
      end
      if (bus.im_req) check("req_align", 32'(bus.im_addr[1:0]), 0);
      if (bus.im_req && bus.im_ack && !fl) acks++;
      if (bus.out_valid && bus.out_ready && !fl) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_empty: got output pc %h, expected none at %0t", bus.out_pc, $time);
        end else begin
          e = sb.pop_front();
          check("sb_pc", bus.out_pc, e.pc);
          check("sb_inst", bus.out_inst, e.inst);
          check("sb_mis", 32'(bus.out_misaligned), 32'(e.mis));
        end
      end
      pend_q <= bus.im_req && !bus.im_ack;
      addr_q <= bus.im_addr;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
  initial begin
    int a0, r;
    logic [31:0] t;
    logic ex;
    resetb = 1'b0;
    redirect_valid = 1'b0;
    exception_take = 1'b0;
    redirect_pc = '0;
    bus.out_ready = 1'b0;
    step(3);
    @(negedge clk);
    check("rst_req", 32'(bus.im_req), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_addr", bus.im_addr, RV);
    step(1);
    resetb = 1'b1;
    bus.out_ready = 1'b1;
    restart(RV);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("seq_req", 32'(bus.im_req), 1);
      check("seq_addr", bus.im_addr, 32'(4 * i));
      check("seq_valid", 32'(bus.out_valid), i > 0 ? 1 : 0);
      if (i > 0) check("seq_pc", bus.out_pc, 32'(4 * (i - 1)));
    end
    step(1);
    bus.out_ready = 1'b0;
    flush(1'b0, 1'b1, 32'h40);
    a0 = acks;
    step(8);
    @(negedge clk);
    check("full_acks", 32'(acks - a0), 4);
    check("full_req", 32'(bus.im_req), 0);
    check("full_head", bus.out_pc, 32'h40);
    step(1);
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    step(5);
    @(negedge clk);
    check("refill_acks", 32'(acks - a0), 5);
    check("refill_req", 32'(bus.im_req), 0);
    step(1);
    bus.out_ready = 1'b1;
    step(4);
    flush(1'b0, 1'b1, 32'h20);
    ack_pct = 0;
    flush(1'b0, 1'b1, 32'h100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_addr", bus.im_addr, 32'h20);
      check("wait_req", 32'(bus.im_req), 1);
    end
    ack_pct = 100;
    @(negedge clk);
    check("ack_addr", bus.im_addr, 32'h20);
    @(negedge clk);
    check("redir_addr", bus.im_addr, 32'h100);
    check("redir_req", 32'(bus.im_req), 1);
    @(negedge clk);
    check("redir_valid", 32'(bus.out_valid), 1);
    check("redir_pc", bus.out_pc, 32'h100);
    step(1);
    flush(1'b1, 1'b1, 32'h200);
    @(negedge clk);
    check("exc_addr", bus.im_addr, EV);
    check("exc_req", 32'(bus.im_req), 1);
    check("exc_empty", 32'(bus.out_valid), 0);
    step(4);
    bus.out_ready = 1'b0;
    flush(1'b0, 1'b1, 32'h102);
    @(negedge clk);
    check("mis_noreq", 32'(bus.im_req), 0);
    @(negedge clk);
    check("mis_valid", 32'(bus.out_valid), 1);
    check("mis_pc", bus.out_pc, 32'h102);
    check("mis_inst", bus.out_inst, NOP_I);
    check("mis_flag", 32'(bus.out_misaligned), 1);
    step(1);
    bus.out_ready = 1'b1;
    r = 0;
    repeat (6) begin
      @(negedge clk);
      r += int'(bus.im_req);
    end
    check("halt_reqs", 32'(r), 0);
    check("halt_empty", 32'(bus.out_valid), 0);
    step(1);
    flush(1'b0, 1'b1, 32'h300);
    @(negedge clk);
    check("resume_addr", bus.im_addr, 32'h300);
    check("resume_req", 32'(bus.im_req), 1);
    step(4);
    flush(1'b0, 1'b1, 32'hffff_fffc);
    @(negedge clk);
    check("wrap_top", bus.im_addr, 32'hffff_fffc);
    @(negedge clk);
    check("wrap_zero", bus.im_addr, 32'h0);
    step(4);
    ack_pct = 60;
    repeat (400) begin
      bus.out_ready = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) begin
        t = ($urandom & 32'h0000_0ffc) | (($urandom_range(4) == 0) ? 32'($urandom_range(3)) : 32'd0);
        ex = ($urandom_range(3) == 0);
        flush(ex, !ex || ($urandom_range(1) == 1), t);
      end else step(1);
    end
    bus.out_ready = 1'b1;
    ack_pct = 100;
    step(10);
    ack_pct = 0;
    flush(1'b0, 1'b1, 32'h500);
    step(1);
    resetb = 1'b0;
    #1;
    check("arst_req", 32'(bus.im_req), 0);
    check("arst_valid", 32'(bus.out_valid), 0);
    check("arst_addr", bus.im_addr, RV);
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
